// File: rtl/axi_defs_pkg.sv
// Shared AXI encodings and FSM state codes for the slave memory model.
//   Burst types : BURST_FIXED / BURST_INCR / BURST_WRAP (2'b11 is reserved)
//   Responses   : RESP_OKAY / RESP_SLVERR
//   Read FSM    : R_IDLE, R_WAIT, R_BURST
//   Write FSM   : W_IDLE, W_WAIT, W_DATA, W_RESP
package axi_defs_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_WAIT  = 2'd1;
  localparam logic [1:0] R_BURST = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_WAIT = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  // WRAP and the reserved encoding both have bit 1 set; the model walks
  // them like INCR but flags the burst as an error.
  function automatic logic burst_is_error(input logic [1:0] burst);
    return burst[1];
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Byte-enabled word storage for the AXI slave memory model.
//   clk       : write clock
//   wr_en     : AXI write strobe (one word per cycle)
//   wr_addr   : AXI write word index
//   wr_strb   : per-byte enables for the AXI write
//   wr_data   : AXI write data
//   bd_we     : backdoor whole-word write enable
//   bd_addr   : backdoor word index
//   bd_wdata  : backdoor write data
//   rd_addr   : read word index
//   rd_data   : combinational read data (pre-edge contents)
// Contents are never reset.
module axi_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    bd_we,
  input  logic [ADDR_WIDTH-1:0]   bd_addr,
  input  logic [DATA_WIDTH-1:0]   bd_wdata,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // The backdoor assignment comes last so it overrides an AXI write to
  // the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wr_strb[b]) mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
    if (bd_we) mem[bd_addr] <= bd_wdata;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axi_slave_mem_model.sv
// AXI4 slave memory model with independent read and write engines.
//   CLK, RST              : clock, asynchronous active-low reset
//   AW*/W*/B*             : write address, data and response channels
//   AR*/R*                : read address and data channels
//   BD_WE/BD_ADDR/BD_WDATA: backdoor whole-word preload port
// Read data is registered from the array one beat ahead, so a word
// written in the same cycle it is fetched returns its old value.
module axi_slave_mem_model
  import axi_defs_pkg::*;
#(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_OFFSET_WIDTH   = 32,
  parameter int C_ID_WIDTH       = 4,
  parameter int C_MEM_WORDS_LOG2 = 12,
  parameter int C_RD_LATENCY     = 2,
  parameter int C_WR_LATENCY     = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [C_ID_WIDTH-1:0]         AWID,
  input  logic [C_OFFSET_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                    AWLEN,
  input  logic [2:0]                    AWSIZE,
  input  logic [1:0]                    AWBURST,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                          WLAST,
  input  logic                          WVALID,
  output logic                          WREADY,
  output logic [C_ID_WIDTH-1:0]         BID,
  output logic [1:0]                    BRESP,
  output logic                          BVALID,
  input  logic                          BREADY,
  input  logic [C_ID_WIDTH-1:0]         ARID,
  input  logic [C_OFFSET_WIDTH-1:0]     ARADDR,
  input  logic [7:0]                    ARLEN,
  input  logic [2:0]                    ARSIZE,
  input  logic [1:0]                    ARBURST,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  output logic [C_ID_WIDTH-1:0]         RID,
  output logic [C_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RLAST,
  output logic                          RVALID,
  input  logic                          RREADY,
  input  logic                          BD_WE,
  input  logic [C_MEM_WORDS_LOG2-1:0]   BD_ADDR,
  input  logic [C_AXI_DATA_WIDTH-1:0]   BD_WDATA
);

  localparam int BYTES    = C_AXI_DATA_WIDTH / 8;
  localparam int ADDR_LSB = (C_AXI_DATA_WIDTH == 64) ? 3 : 2;
  localparam int MW       = C_MEM_WORDS_LOG2;
  localparam int OW       = C_OFFSET_WIDTH;

  logic out_of_reset;

  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic [7:0]            r_len;
  logic [OW-1:0]         r_addr;
  logic [OW-1:0]         r_next_addr;
  logic                  r_fixed;
  logic [1:0]            r_resp;
  logic [C_ID_WIDTH-1:0] r_id;
  logic [C_AXI_DATA_WIDTH-1:0] r_data;

  logic [1:0]            w_state;
  logic [7:0]            w_cnt;
  logic [7:0]            w_len;
  logic [OW-1:0]         w_addr;
  logic [OW-1:0]         w_next_addr;
  logic                  w_fixed;
  logic                  w_err;
  logic [C_ID_WIDTH-1:0] w_id;

  logic [MW-1:0]               mem_rd_addr;
  logic [C_AXI_DATA_WIDTH-1:0] mem_rd_data;

  // Holds both address-ready outputs low until the first edge after
  // reset release, even though the FSMs are already idle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) out_of_reset <= 1'b0;
    else      out_of_reset <= 1'b1;
  end

  assign r_next_addr = r_fixed ? r_addr : r_addr + OW'(BYTES);
  assign w_next_addr = w_fixed ? w_addr : w_addr + OW'(BYTES);

  // While bursting, fetch the word for the following beat; otherwise the
  // first beat's word, loaded on the R_WAIT -> R_BURST transition.
  assign mem_rd_addr = (r_state == R_BURST) ? r_next_addr[ADDR_LSB +: MW]
                                            : r_addr[ADDR_LSB +: MW];

  axi_mem_array #(
    .DATA_WIDTH (C_AXI_DATA_WIDTH),
    .ADDR_WIDTH (MW)
  ) u_mem (
    .clk      (CLK),
    .wr_en    (WVALID && WREADY),
    .wr_addr  (w_addr[ADDR_LSB +: MW]),
    .wr_strb  (WSTRB),
    .wr_data  (WDATA),
    .bd_we    (BD_WE),
    .bd_addr  (BD_ADDR),
    .bd_wdata (BD_WDATA),
    .rd_addr  (mem_rd_addr),
    .rd_data  (mem_rd_data)
  );

  // Read engine: R_WAIT uses r_cnt as the latency counter, R_BURST reuses
  // it as the zero-based beat index.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_addr  <= '0;
      r_fixed <= 1'b0;
      r_resp  <= RESP_OKAY;
      r_id    <= '0;
      r_data  <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            r_id    <= ARID;
            r_addr  <= ARADDR;
            r_len   <= ARLEN;
            r_fixed <= (ARBURST == BURST_FIXED);
            r_resp  <= (burst_is_error(ARBURST) || ARSIZE != 3'(ADDR_LSB))
                       ? RESP_SLVERR : RESP_OKAY;
            r_cnt   <= '0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_cnt == 8'(C_RD_LATENCY)) begin
            r_cnt   <= '0;
            r_data  <= mem_rd_data;
            r_state <= R_BURST;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        R_BURST: begin
          if (RREADY) begin
            if (r_cnt == r_len) begin
              r_state <= R_IDLE;
            end else begin
              r_cnt  <= r_cnt + 8'd1;
              r_addr <= r_next_addr;
              r_data <= mem_rd_data;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign ARREADY = out_of_reset && (r_state == R_IDLE);
  assign RVALID  = (r_state == R_BURST);
  assign RLAST   = (r_state == R_BURST) && (r_cnt == r_len);
  assign RDATA   = r_data;
  assign RID     = r_id;
  assign RRESP   = r_resp;

  // Write engine: a WLAST mismatch only marks the response; the beat
  // count alone decides when the data phase ends.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      w_state <= W_IDLE;
      w_cnt   <= '0;
      w_len   <= '0;
      w_addr  <= '0;
      w_fixed <= 1'b0;
      w_err   <= 1'b0;
      w_id    <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (AWVALID && AWREADY) begin
            w_id    <= AWID;
            w_addr  <= AWADDR;
            w_len   <= AWLEN;
            w_fixed <= (AWBURST == BURST_FIXED);
            w_err   <= burst_is_error(AWBURST) || (AWSIZE != 3'(ADDR_LSB));
            w_cnt   <= '0;
            w_state <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (w_cnt == 8'(C_WR_LATENCY)) begin
            w_cnt   <= '0;
            w_state <= W_DATA;
          end else begin
            w_cnt <= w_cnt + 8'd1;
          end
        end
        W_DATA: begin
          if (WVALID) begin
            if (WLAST != (w_cnt == w_len)) w_err <= 1'b1;
            if (w_cnt == w_len) begin
              w_state <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= w_next_addr;
            end
          end
        end
        W_RESP: begin
          if (BREADY) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  assign AWREADY = out_of_reset && (w_state == W_IDLE);
  assign WREADY  = (w_state == W_DATA);
  assign BVALID  = (w_state == W_RESP);
  assign BID     = w_id;
  assign BRESP   = w_err ? RESP_SLVERR : RESP_OKAY;

endmodule

// File: tb/tb_axi_slave_mem_model.sv
// Self-checking bench for axi_slave_mem_model (default parameters:
// 32-bit data, 4096 words, read latency 2, write latency 1). A word-array
// reference model tracks memory contents; expected responses come from the
// burst/size/WLAST rules.
module tb_axi_slave_mem_model;

  logic        CLK;
  logic        RST;
  logic [3:0]  AWID, ARID, BID, RID;
  logic [31:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, BRESP, RRESP;
  logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic [31:0] WDATA, RDATA, BD_WDATA;
  logic [3:0]  WSTRB;
  logic        BD_WE;
  logic [11:0] BD_ADDR;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_mem [4096];
  logic [31:0] wbuf_data [256];
  logic [3:0]  wbuf_strb [256];

  axi_slave_mem_model dut (
    .CLK(CLK), .RST(RST),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID),
    .RREADY(RREADY),
    .BD_WE(BD_WE), .BD_ADDR(BD_ADDR), .BD_WDATA(BD_WDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr / 32'd4) % 32'd4096);
  endfunction

  function automatic logic [1:0] expected_resp(input logic [1:0] burst,
                                               input logic [2:0] size,
                                               input bit wlast_bad);
    return (burst == 2'b10 || burst == 2'b11 || size != 3'd2 || wlast_bad)
           ? 2'b10 : 2'b00;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Backdoor preload of one word, mirrored into the reference model.
  task automatic applyStimulus(input int idx, input logic [31:0] val);
    BD_WE = 1'b1; BD_ADDR = 12'(idx); BD_WDATA = val;
    tick();
    BD_WE = 1'b0;
    model_mem[idx] = val;
  endtask

  // Full write burst using wbuf_data/wbuf_strb; WLAST is raised on
  // last_beat. With collide set, beat 0 races a backdoor write to its word.
  task automatic axiWrite(input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int last_beat,
                          input bit collide);
    int n;
    int w;
    logic [31:0] a;
    AWID = id; AWADDR = addr; AWLEN = 8'(len); AWSIZE = size; AWBURST = burst;
    AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin tick(); n++; end
    checkOutput("awready", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
    checkOutput("wready_during_wait", WREADY, 0);
    for (int i = 0; i <= len; i++) begin
      WDATA = wbuf_data[i]; WSTRB = wbuf_strb[i];
      WLAST = (i == last_beat); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 50) begin tick(); n++; end
      checkOutput("wready", WREADY, 1);
      a = addr + ((burst == 2'b00) ? 32'd0 : 32'(i * 4));
      w = word_of(a);
      if (collide && i == 0) begin
        BD_WE = 1'b1; BD_ADDR = 12'(w); BD_WDATA = 32'hA5A5_0F0F ^ addr;
      end
      tick();
      BD_WE = 1'b0;
      for (int b = 0; b < 4; b++)
        if (wbuf_strb[i][b]) model_mem[w][8*b +: 8] = wbuf_data[i][8*b +: 8];
      if (collide && i == 0) model_mem[w] = 32'hA5A5_0F0F ^ addr;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    checkOutput("wready_after_last", WREADY, 0);
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 50) begin tick(); n++; end
    checkOutput("bvalid", BVALID, 1);
    checkOutput("bresp", BRESP, expected_resp(burst, size, last_beat != len));
    checkOutput("bid", BID, id);
    tick();
    BREADY = 1'b0;
    checkOutput("bvalid_clear", BVALID, 0);
    checkOutput("awready_back", AWREADY, 1);
  endtask

  // Full read burst checked beat by beat against the model. exp_lat >= 0
  // checks edges from AR handshake to first RVALID; stall holds RREADY low
  // for 5 cycles on beat 1.
  task automatic axiRead(input logic [3:0] id, input logic [31:0] addr,
                         input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int exp_lat,
                         input bit stall);
    int n;
    logic [31:0] a;
    logic [31:0] held_data;
    logic        held_last;
    ARID = id; ARADDR = addr; ARLEN = 8'(len); ARSIZE = size; ARBURST = burst;
    ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin tick(); n++; end
    checkOutput("arready", ARREADY, 1);
    tick();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 50) begin tick(); n++; end
    if (exp_lat >= 0) checkOutput("rd_latency", 64'(n), 64'(exp_lat));
    for (int i = 0; i <= len; i++) begin
      n = 0;
      while (!RVALID && n < 50) begin tick(); n++; end
      checkOutput("rvalid", RVALID, 1);
      if (stall && i == 1) begin
        held_data = RDATA; held_last = RLAST;
        repeat (5) tick();
        checkOutput("stall_rdata", RDATA, held_data);
        checkOutput("stall_rlast", RLAST, held_last);
        checkOutput("stall_rvalid", RVALID, 1);
      end
      a = addr + ((burst == 2'b00) ? 32'd0 : 32'(i * 4));
      checkOutput("rdata", RDATA, model_mem[word_of(a)]);
      checkOutput("rlast", RLAST, (i == len));
      checkOutput("rresp", RRESP, expected_resp(burst, size, 1'b0));
      checkOutput("rid", RID, id);
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    checkOutput("rvalid_clear", RVALID, 0);
    checkOutput("arready_back", ARREADY, 1);
  endtask

  initial begin
    logic [31:0] base;
    int len;
    logic [1:0] burst;

    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'd2; AWBURST = 2'b01; AWVALID = 0;
    WDATA = '0; WSTRB = '0; WLAST = 0; WVALID = 0; BREADY = 0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = 3'd2; ARBURST = 2'b01; ARVALID = 0;
    RREADY = 0; BD_WE = 0; BD_ADDR = '0; BD_WDATA = '0;
    RST = 1'b1;
    #1 RST = 1'b0;
    #2;
    $display("[TB] reset asserted, zeroing memory through backdoor");
    checkOutput("reset_arready", ARREADY, 0);
    checkOutput("reset_awready", AWREADY, 0);
    checkOutput("reset_rvalid", RVALID, 0);
    checkOutput("reset_bvalid", BVALID, 0);
    checkOutput("reset_rdata", RDATA, 0);

    for (int i = 0; i < 4096; i++) applyStimulus(i, 32'h0);

    RST = 1'b1;
    #1;
    checkOutput("release_arready_pre_edge", ARREADY, 0);
    tick();
    checkOutput("release_arready", ARREADY, 1);
    checkOutput("release_awready", AWREADY, 1);

    $display("[TB] preload and INCR read, latency 2");
    applyStimulus(0, 32'h0000_0013);
    applyStimulus(1, 32'h0010_0093);
    applyStimulus(2, 32'h0020_0113);
    applyStimulus(3, 32'h0030_8193);
    axiRead(4'h2, 32'h0, 3, 2'b01, 3'd2, 3, 1'b0);

    $display("[TB] strobed INCR write at 0x40");
    wbuf_data[0] = 32'hDEAD_BEEF; wbuf_strb[0] = 4'hF;
    wbuf_data[1] = 32'hCAFE_BABE; wbuf_strb[1] = 4'h3;
    axiWrite(4'h5, 32'h40, 1, 2'b01, 3'd2, 1, 1'b0);
    axiRead(4'h1, 32'h40, 1, 2'b01, 3'd2, -1, 1'b0);
    checkOutput("word_0x44_kept_high_zero", model_mem[17], 32'h0000_BABE);

    $display("[TB] read with RREADY stall");
    axiRead(4'h3, 32'h0, 3, 2'b01, 3'd2, -1, 1'b1);

    $display("[TB] early WLAST and WRAP read");
    for (int i = 0; i < 4; i++) begin
      wbuf_data[i] = 32'h1111_0000 + 32'(i); wbuf_strb[i] = 4'hF;
    end
    axiWrite(4'h7, 32'h80, 3, 2'b01, 3'd2, 1, 1'b0);
    axiRead(4'h7, 32'h80, 3, 2'b10, 3'd2, -1, 1'b0);

    $display("[TB] FIXED burst with zero strobe");
    wbuf_data[0] = 32'h1234_5678; wbuf_strb[0] = 4'hF;
    wbuf_data[1] = 32'hFFFF_FFFF; wbuf_strb[1] = 4'h0;
    wbuf_data[2] = 32'hABCD_0000; wbuf_strb[2] = 4'hC;
    axiWrite(4'h9, 32'hC0, 2, 2'b00, 3'd2, 2, 1'b0);
    axiRead(4'h9, 32'hC0, 2, 2'b00, 3'd2, -1, 1'b0);

    $display("[TB] size mismatch and reserved burst");
    axiRead(4'hA, 32'h0, 1, 2'b01, 3'd1, -1, 1'b0);
    wbuf_data[0] = 32'h0BAD_F00D; wbuf_strb[0] = 4'hF;
    axiWrite(4'hB, 32'h200, 0, 2'b11, 3'd2, 0, 1'b0);

    $display("[TB] address wrap 0x4000 aliases word 0");
    wbuf_data[0] = 32'h5555_AAAA; wbuf_strb[0] = 4'hF;
    axiWrite(4'h4, 32'h4000, 0, 2'b01, 3'd2, 0, 1'b0);
    axiRead(4'h4, 32'h0, 0, 2'b01, 3'd2, -1, 1'b0);

    $display("[TB] backdoor collides with AXI write");
    wbuf_data[0] = 32'h7777_7777; wbuf_strb[0] = 4'hF;
    axiWrite(4'h6, 32'h100, 0, 2'b01, 3'd2, 0, 1'b1);
    axiRead(4'h6, 32'h100, 0, 2'b01, 3'd2, -1, 1'b0);

    $display("[TB] randomized write/read bursts");
    for (int it = 0; it < 12; it++) begin
      len = $urandom_range(0, 7);
      base = (32'($urandom_range(0, 255)) << 2) | (32'($urandom_range(0, 3)) << 14);
      burst = 2'($urandom_range(0, 1));
      for (int i = 0; i <= len; i++) begin
        wbuf_data[i] = $urandom; wbuf_strb[i] = 4'($urandom_range(0, 15));
      end
      axiWrite(4'($urandom_range(0, 15)), base, len, burst, 3'd2, len, 1'b0);
      axiRead(4'($urandom_range(0, 15)), base, len, 2'($urandom_range(0, 3)),
              3'd2, -1, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during read burst");
    ARID = 4'h8; ARADDR = 32'h0; ARLEN = 8'd3; ARSIZE = 3'd2; ARBURST = 2'b01;
    ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      while (!RVALID) tick();
      RREADY = 1'b1;
      tick();
      RREADY = 1'b0;
    end
    checkOutput("beat2_rvalid", RVALID, 1);
    RST = 1'b0;
    #1;
    checkOutput("midburst_reset_rvalid", RVALID, 0);
    checkOutput("midburst_reset_rlast", RLAST, 0);
    checkOutput("midburst_reset_arready", ARREADY, 0);
    checkOutput("midburst_reset_rdata", RDATA, 0);
    tick();
    RST = 1'b1;
    #1;
    tick();
    checkOutput("post_reset_arready", ARREADY, 1);
    checkOutput("post_reset_rvalid", RVALID, 0);
    axiRead(4'h8, 32'h0, 3, 2'b01, 3'd2, 3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
